// File: rtl/neuron_input_loader.sv
// Pixel-stream to float frame loader: gathers N_INPUTS pixels into a shadow buffer, then commits
// them to out_data in one cycle. Define LOADER_NORMALIZE_EN to scale pixels into [0,1).
module neuron_input_loader #(
  parameter int unsigned N_INPUTS = 49
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic [31:0] out_data [N_INPUTS-1:0],
  output logic        out_valid,
  output logic        sof_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned IdxW = $clog2(N_INPUTS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_INPUTS - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

`ifdef LOADER_NORMALIZE_EN
  localparam logic [7:0] ExpBase = 8'd119;
`else
  localparam logic [7:0] ExpBase = 8'd127;
`endif

  typedef enum logic [1:0] {StIdle, StFill, StCommit} state_e;

  // Exact u8 -> binary32; every 8-bit value fits the 23-bit mantissa, so no rounding.
  function automatic logic [31:0] pix_to_float(input logic [7:0] p);
    logic [2:0]  k;
    logic [22:0] mant;
    logic [7:0]  e;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) k = 3'(i);
    end
    mant = {15'd0, p} << (5'd23 - {2'b00, k});
    e    = ExpBase + {5'd0, k};
    if (p == 8'd0) return 32'd0;
    return {1'b0, e, mant};
  endfunction

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            ready_q, ready_d;
  logic            out_valid_q;
  logic            sof_err_q, sof_err_d;
  logic [15:0]     frame_cnt_q;
  logic [31:0]     shadow_q   [N_INPUTS-1:0];
  logic [31:0]     out_data_q [N_INPUTS-1:0];

  logic            accept;
  logic            commit;
  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  logic [31:0]     pix_f;

  assign accept = pix_valid & ready_q;
  assign pix_f  = pix_to_float(pix_data);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    sof_err_d = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && pix_sof) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          idx_d   = IdxOne;
          state_d = StFill;
        end
      end
      StFill: begin
        if (accept) begin
          wr_en = 1'b1;
          // A new sof restarts the frame, even on the last pixel position.
          if (pix_sof) begin
            wr_idx    = '0;
            idx_d     = IdxOne;
            sof_err_d = (idx_q != '0);
          end else if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StCommit;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d != StCommit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      out_valid_q <= commit;
      sof_err_q   <= sof_err_d;
      if (commit) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) shadow_q[i] <= '0;
    end else if (wr_en) begin
      shadow_q[wr_idx] <= pix_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) out_data_q[i] <= '0;
    end else if (commit) begin
      out_data_q <= shadow_q;
    end
  end

  assign pix_ready = ready_q;
  assign out_valid = out_valid_q;
  assign sof_err   = sof_err_q;
  assign frame_cnt = frame_cnt_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_input_loader.sv
// Directed bench for neuron_input_loader: vector tables for the float conversion plus
// hand-written sequences for commit timing, sof restarts, idle drops and mid-frame reset.
module tb_neuron_input_loader;

  localparam int N = 49;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_sof = 1'b0;
  logic        pix_ready;
  logic [31:0] out_data [N-1:0];
  logic        out_valid;
  logic        sof_err;
  logic [15:0] frame_cnt;

  neuron_input_loader #(.N_INPUTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sof_err   (sof_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pix;
    logic [31:0] f_int;
    logic [31:0] f_norm;
  } vec_t;

  vec_t tbl  [8];
  vec_t spot [6];

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0;
  int se_cnt = 0;
  int rdy_low = 0;

  always @(negedge clk) begin
    ov_cnt  <= ov_cnt + (out_valid ? 1 : 0);
    se_cnt  <= se_cnt + (sof_err ? 1 : 0);
    rdy_low <= rdy_low + ((rst_n && !pix_ready) ? 1 : 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] expf(input vec_t v);
`ifdef LOADER_NORMALIZE_EN
    return v.f_norm;
`else
    return v.f_int;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p, input logic sof);
    pix_valid = 1'b1;
    pix_data  = p;
    pix_sof   = sof;
    step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Entered one step after the last beat is accepted (COMMIT cycle).
  task automatic finish_frame(input logic [15:0] fc);
    chk("commit_ready", 32'(pix_ready), 32'd0);
    chk("commit_ov_early", 32'(out_valid), 32'd0);
    step();
    chk("ov_pulse", 32'(out_valid), 32'd1);
    chk("frame_cnt", 32'(frame_cnt), 32'(fc));
    step();
    chk("ov_clear", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(pix_ready), 32'd1);
  endtask

  initial begin
    int ov0, se0, r0;
    logic [31:0] e128, e255, e1, e2;

    tbl[0] = '{8'd0,   32'h00000000, 32'h00000000};
    tbl[1] = '{8'd1,   32'h3F800000, 32'h3B800000};
    tbl[2] = '{8'd2,   32'h40000000, 32'h3C000000};
    tbl[3] = '{8'd3,   32'h40400000, 32'h3C400000};
    tbl[4] = '{8'd128, 32'h43000000, 32'h3F000000};
    tbl[5] = '{8'd255, 32'h437F0000, 32'h3F7F0000};
    tbl[6] = '{8'd100, 32'h42C80000, 32'h3EC80000};
    tbl[7] = '{8'd17,  32'h41880000, 32'h3D880000};

    spot[0] = '{8'd0,  32'h00000000, 32'h00000000};
    spot[1] = '{8'd1,  32'h3F800000, 32'h3B800000};
    spot[2] = '{8'd2,  32'h40000000, 32'h3C000000};
    spot[3] = '{8'd3,  32'h40400000, 32'h3C400000};
    spot[4] = '{8'd7,  32'h40E00000, 32'h3CE00000};
    spot[5] = '{8'd48, 32'h42400000, 32'h3E400000};

    e1   = expf(tbl[1]);
    e2   = expf(tbl[2]);
    e128 = expf(tbl[4]);
    e255 = expf(tbl[5]);

    // Reset values
    #1;
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_out0", out_data[0], 32'd0);
    chk("rst_out48", out_data[48], 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(pix_ready), 32'd1);

    // Back-to-back frame, p = i
    for (int i = 0; i < N; i++) beat(8'(i), i == 0);
    finish_frame(16'd1);
    for (int i = 0; i < 6; i++) chk($sformatf("f1_out[%0d]", spot[i].pix),
                                    out_data[spot[i].pix], expf(spot[i]));
    chk("f1_no_sof_err", 32'(se_cnt), 32'd0);

    // Non-sof beats in IDLE are dropped
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      beat(8'hAA, 1'b0);
      chk("idle_ready", 32'(pix_ready), 32'd1);
    end
    step();
    step();
    chk("idle_no_ov", 32'(ov_cnt), 32'(ov0));
    chk("idle_out1", out_data[1], expf(spot[1]));

    // Frame with random gaps in pix_valid
    r0  = rdy_low;
    se0 = se_cnt;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) step();
      beat(tbl[i % 8].pix, i == 0);
    end
    finish_frame(16'd2);
    for (int i = 0; i < N; i++) chk($sformatf("f2_out[%0d]", i), out_data[i], expf(tbl[i % 8]));
    chk("f2_ready_low_cycles", 32'(rdy_low - r0), 32'd1);
    chk("f2_no_sof_err", 32'(se_cnt - se0), 32'd0);

    // sof at pixel 20 restarts the frame
    ov0 = ov_cnt;
    se0 = se_cnt;
    for (int i = 0; i < 20; i++) beat(8'd9, i == 0);
    beat(8'd255, 1'b1);
    chk("sof20_err", 32'(sof_err), 32'd1);
    beat(8'd128, 1'b0);
    chk("sof20_err_clear", 32'(sof_err), 32'd0);
    for (int i = 2; i < N; i++) beat(8'd128, 1'b0);
    chk("sof20_no_early_ov", 32'(ov_cnt - ov0), 32'd0);
    finish_frame(16'd3);
    chk("sof20_out0", out_data[0], e255);
    chk("sof20_out20", out_data[20], e128);
    chk("sof20_out48", out_data[48], e128);
    chk("sof20_err_pulses", 32'(se_cnt - se0), 32'd1);

    // sof on the final pixel position wins over completion
    ov0 = ov_cnt;
    se0 = se_cnt;
    for (int i = 0; i < N - 1; i++) beat(8'd9, i == 0);
    beat(8'd1, 1'b1);
    chk("sof_last_err", 32'(sof_err), 32'd1);
    chk("sof_last_ready", 32'(pix_ready), 32'd1);
    for (int i = 1; i < N; i++) beat(8'd2, 1'b0);
    chk("sof_last_no_early_ov", 32'(ov_cnt - ov0), 32'd0);
    finish_frame(16'd4);
    chk("sof_last_out0", out_data[0], e1);
    chk("sof_last_out48", out_data[48], e2);
    chk("sof_last_err_pulses", 32'(se_cnt - se0), 32'd1);

    // Reset in the middle of a fill
    for (int i = 0; i < 10; i++) beat(8'd3, i == 0);
    ov0 = ov_cnt;
    se0 = se_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_out0", out_data[0], 32'd0);
    chk("midrst_out48", out_data[48], 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_ready", 32'(pix_ready), 32'd0);
    chk("midrst_ov", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("midrst_no_ov", 32'(ov_cnt - ov0), 32'd0);
    chk("midrst_no_sof_err", 32'(se_cnt - se0), 32'd0);
    chk("midrst_ready_back", 32'(pix_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
